// File: rtl/dmem_responder_if.sv
// Request/response bundle between the LSU pipe-6 port and the data memory.
// Master is the requester, slave is the memory responder.
interface dmem_responder_if;
    logic        req_m_op;
    logic        req_gwe;
    logic        req_rd;
    logic        req_bw0;
    logic        req_bw1;
    logic        req_bw2;
    logic        req_bw3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    modport master (
        output req_m_op, req_gwe, req_rd,
        output req_bw0, req_bw1, req_bw2, req_bw3,
        output req_addr, req_data,
        input  busy, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  req_m_op, req_gwe, req_rd,
        input  req_bw0, req_bw1, req_bw2, req_bw3,
        input  req_addr, req_data,
        output busy, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: in-order request queue, byte-lane word array,
// fixed-latency read/fault response pipe.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          RD_LATENCY  = 2
) (
    input logic             clk,
    input logic             nrst,
    input logic             mem_stall,
    dmem_responder_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
    localparam logic [31:0]   DEPTH_L = 32'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic          q_wr    [FIFO_DEPTH];
    logic          q_fault [FIFO_DEPTH];
    logic [3:0]    q_mask  [FIFO_DEPTH];
    logic [AW-1:0] q_idx   [FIFO_DEPTH];
    logic [31:0]   q_data  [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          p_v [RD_LATENCY];
    logic          p_f [RD_LATENCY];
    logic [31:0]   p_d [RD_LATENCY];

    logic          in_wr;
    logic [3:0]    in_mask;
    logic [31:0]   offs;
    logic [1:0]    offs_unused;
    logic          in_oor;
    logic          busy_q;
    logic          push;
    logic          pop;
    logic          h_wr;
    logic          h_fault;
    logic [3:0]    h_mask;
    logic [AW-1:0] h_idx;
    logic [31:0]   h_data;
    logic          s_v;
    logic          s_f;
    logic [31:0]   s_d;

    // Classify the incoming beat; range is decided once, at push time.
    always_comb begin
        in_wr   = bus.req_gwe | bus.req_bw0 | bus.req_bw1
                | bus.req_bw2 | bus.req_bw3;
        in_mask = {4{bus.req_gwe}}
                | {bus.req_bw3, bus.req_bw2, bus.req_bw1, bus.req_bw0};
        offs    = bus.req_addr - BASE_ADDR;
        in_oor  = (bus.req_addr < BASE_ADDR)
                | ({2'b00, offs[31:2]} >= DEPTH_L);
        busy_q  = (count == FULL);
        push    = bus.req_m_op & ~busy_q & (in_wr | bus.req_rd);
        pop     = (count != '0) & ~mem_stall;
    end

    assign offs_unused = offs[1:0];

    assign h_wr    = q_wr[rd_ptr];
    assign h_fault = q_fault[rd_ptr];
    assign h_mask  = q_mask[rd_ptr];
    assign h_idx   = q_idx[rd_ptr];
    assign h_data  = q_data[rd_ptr];

    // Queue payload; only the pointers and count need a reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]    <= in_wr;
            q_fault[wr_ptr] <= in_oor;
            q_mask[wr_ptr]  <= in_mask;
            q_idx[wr_ptr]   <= offs[AW+1:2];
            q_data[wr_ptr]  <= bus.req_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Word array keeps its contents across reset; lanes commit at write pop.
    always_ff @(posedge clk) begin
        if (pop && h_wr && !h_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (h_mask[i]) mem[h_idx][8*i +: 8] <= h_data[8*i +: 8];
            end
        end
    end

    // Response launch: reads always answer, writes answer only on fault.
    always_comb begin
        s_v = pop & (~h_wr | h_fault);
        s_f = pop & h_fault;
        s_d = (pop && !h_wr && !h_fault) ? mem[h_idx] : 32'h0;
    end

    // Unstallable fixed-latency response pipe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                p_v[k] <= 1'b0;
                p_f[k] <= 1'b0;
                p_d[k] <= 32'h0;
            end
        end else begin
            p_v[0] <= s_v;
            p_f[0] <= s_f;
            p_d[0] <= s_d;
            for (int k = 1; k < RD_LATENCY; k++) begin
                p_v[k] <= p_v[k-1];
                p_f[k] <= p_f[k-1];
                p_d[k] <= p_d[k-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rsp_valid = p_v[RD_LATENCY-1];
    assign bus.rsp_fault = p_f[RD_LATENCY-1];
    assign bus.rsp_data  = p_d[RD_LATENCY-1];
endmodule
